// File: rtl/maze_stream_tx.sv
// Host-side driver/checker for a 15x15 maze solver: stores a maze written row by
// row, streams it serially to the solver, then validates the returned path.
module maze_stream_tx #(
  parameter int N       = 15,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         row_we,
  input  logic [3:0]   row_addr,
  input  logic [N-1:0] row_data,
  input  logic         start,
  input  logic         sol_valid,
  input  logic         sol_not_valid,
  input  logic [3:0]   sol_x,
  input  logic [3:0]   sol_y,
  output logic         maze,
  output logic         in_valid,
  output logic         busy,
  output logic         done,
  output logic [2:0]   result,
  output logic [7:0]   path_len
);

  localparam logic [3:0]     LAST  = 4'(N - 1);
  localparam logic [3:0]     ENTRY = 4'(N - 2);
  localparam int             WCW   = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

  localparam logic [2:0] R_PASS      = 3'd0;
  localparam logic [2:0] R_NOT_VALID = 3'd1;
  localparam logic [2:0] R_BAD_START = 3'd2;
  localparam logic [2:0] R_NOT_ADJ   = 3'd3;
  localparam logic [2:0] R_WALL      = 3'd4;
  localparam logic [2:0] R_BAD_END   = 3'd5;
  localparam logic [2:0] R_TIMEOUT   = 3'd6;
  localparam logic [2:0] R_PROTOCOL  = 3'd7;

  // S_NVDRN waits for the solver to drop out_valid after a maze_not_valid reply
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_NVDRN, S_CHECK, S_DONE} state_t;

  state_t         state_q;
  logic [N-1:0]   store_q [N];
  logic [3:0]     r_q, c_q, r_d, c_d;
  logic [WCW-1:0] wcnt_q;
  logic [3:0]     px_q, py_q;
  logic [2:0]     err_q, err_now;
  logic           maze_q, in_valid_q, busy_q, done_q;
  logic [2:0]     result_q;
  logic [7:0]     len_q;
  logic           idle_like, first_bit, in_range, hit_wall, adjacent;
  logic [3:0]     wx, wy, dx, dy;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  // A row written in the start cycle must already appear in the first bit
  assign first_bit = (row_we && row_addr == 4'd0) ? row_data[0] : store_q[0][0];

  // Maze store: host writes only while idle, addresses beyond the maze are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) store_q[i] <= '0;
    end else if (row_we && idle_like && ({1'b0, row_addr} < 5'(N))) begin
      store_q[row_addr] <= row_data;
    end
  end

  // Row-major serial position following the bit currently on the maze output
  always_comb begin
    c_d = (c_q == LAST) ? 4'd0 : c_q + 4'd1;
    r_d = (c_q == LAST) ? r_q + 4'd1 : r_q;
  end

  // Classify the coordinate presented by the solver this cycle
  always_comb begin
    in_range = ({1'b0, sol_x} < 5'(N)) && ({1'b0, sol_y} < 5'(N));
    wx       = in_range ? sol_x : 4'd0;
    wy       = in_range ? sol_y : 4'd0;
    hit_wall = !in_range || store_q[wy][wx];
    dx       = (sol_x > px_q) ? sol_x - px_q : px_q - sol_x;
    dy       = (sol_y > py_q) ? sol_y - py_q : py_q - sol_y;
    adjacent = (dx == 4'd1 && dy == 4'd0) || (dx == 4'd0 && dy == 4'd1);
    err_now  = R_PASS;
    if (state_q == S_WAIT) begin
      if (sol_x != ENTRY || sol_y != ENTRY) err_now = R_BAD_START;
      else if (hit_wall)                    err_now = R_WALL;
    end else begin
      if (!adjacent)          err_now = R_NOT_ADJ;
      else if (hit_wall)      err_now = R_WALL;
      else if (sol_not_valid) err_now = R_PROTOCOL;
    end
  end

  // Transaction FSM with registered stream and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      wcnt_q     <= '0;
      px_q       <= '0;
      py_q       <= '0;
      err_q      <= R_PASS;
      maze_q     <= 1'b0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= R_PASS;
      len_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_SEND;
            r_q        <= '0;
            c_q        <= '0;
            err_q      <= R_PASS;
            maze_q     <= first_bit;
            in_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= R_PASS;
            len_q      <= '0;
          end
        end
        S_SEND: begin
          if (sol_valid) begin
            state_q    <= S_DONE;
            result_q   <= R_PROTOCOL;
            maze_q     <= 1'b0;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else if (r_q == LAST && c_q == LAST) begin
            state_q    <= S_WAIT;
            wcnt_q     <= '0;
            maze_q     <= 1'b0;
            in_valid_q <= 1'b0;
          end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            maze_q <= store_q[r_d][c_d];
          end
        end
        S_WAIT: begin
          if (sol_valid && sol_not_valid) begin
            state_q  <= S_NVDRN;
            result_q <= R_NOT_VALID;
          end else if (sol_valid) begin
            state_q <= S_CHECK;
            px_q    <= sol_x;
            py_q    <= sol_y;
            err_q   <= err_now;
            len_q   <= sat_inc(len_q);
          end else if (wcnt_q == WLAST) begin
            state_q  <= S_DONE;
            result_q <= R_TIMEOUT;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_NVDRN: begin
          if (sol_valid) begin
            result_q <= R_PROTOCOL;
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_CHECK: begin
          if (sol_valid) begin
            px_q  <= sol_x;
            py_q  <= sol_y;
            len_q <= sat_inc(len_q);
            if (err_q == R_PASS) err_q <= err_now;
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (err_q != R_PASS)                      result_q <= err_q;
            else if (px_q == 4'd1 && py_q == 4'd1)    result_q <= R_PASS;
            else                                      result_q <= R_BAD_END;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign maze     = maze_q;
  assign in_valid = in_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign path_len = len_q;

endmodule

// File: tb/tb_maze_stream_tx.sv
// Bench for maze_stream_tx: table of maze/response scenarios, a stream scoreboard
// checked bit by bit, and a result scoreboard popped whenever done rises.
`timescale 1ns/1ps
module tb_maze_stream_tx;
  localparam int N  = 15;
  localparam int TO = 4096;
  localparam int NB = N * N;

  localparam int M_CORR = 0, M_DIAG = 1, M_ROW0 = 2, M_ZERO = 3;
  localparam int R_PATH = 0, R_NV1 = 1, R_NV2 = 2, R_NONE = 3, R_EARLY = 4;
  localparam int P_CORR = 0, P_DIAGJ = 1, P_WALL = 2, P_BADEND = 3, P_BADST = 4, P_CORRNV = 5;

  logic         clk, rst, row_we, start, sol_valid, sol_not_valid;
  logic [3:0]   row_addr, sol_x, sol_y;
  logic [N-1:0] row_data;
  logic         maze, in_valid, busy, done;
  logic [2:0]   result;
  logic [7:0]   path_len;

  maze_stream_tx #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .row_we(row_we), .row_addr(row_addr), .row_data(row_data),
    .start(start), .sol_valid(sol_valid), .sol_not_valid(sol_not_valid),
    .sol_x(sol_x), .sol_y(sol_y), .maze(maze), .in_valid(in_valid), .busy(busy),
    .done(done), .result(result), .path_len(path_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int mz; int rsp; int pid; int exp_res; int exp_len; } vec_t;
  typedef struct { int res; int len; } exp_t;

  vec_t       vt [10];
  exp_t       exp_q [$];
  logic       exp_bits [$];
  logic [8:0] path [$];
  int         n_cmp = 0, n_bad = 0;
  int         iv_cnt = 0, bit_idx = 0;
  logic       mon_b;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream scoreboard: every qualified bit is popped against the stored maze model
  always @(negedge clk) begin
    if (!rst && in_valid) begin
      iv_cnt++;
      if (exp_bits.size() == 0) chk("stream_extra_bit", 1, 0);
      else begin
        mon_b = exp_bits.pop_front();
        chk($sformatf("stream_bit%0d", bit_idx), int'(maze), int'(mon_b));
      end
      bit_idx++;
    end
  end

  function automatic logic [N-1:0] row_of(input int mz, input int r);
    logic [N-1:0] v;
    case (mz)
      M_CORR: begin
        v = '1;
        if (r >= 1 && r <= 13) v[13] = 1'b0;
        if (r == 1) for (int c = 1; c <= 13; c++) v[c] = 1'b0;
      end
      M_DIAG:  begin v = '0; v[r] = 1'b1; end
      M_ROW0:  v = (r == 0) ? '1 : '0;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic pt(input int x, input int y);
    path.push_back({1'b0, 4'(x), 4'(y)});
  endtask

  task automatic add_line(input int x0, input int y0, input int x1, input int y1);
    int x = x0;
    int y = y0;
    for (int k = 0; k < 32; k++) begin
      pt(x, y);
      if (x == x1 && y == y1) break;
      x += (x1 > x) ? 1 : (x1 < x) ? -1 : 0;
      y += (y1 > y) ? 1 : (y1 < y) ? -1 : 0;
    end
  endtask

  task automatic build_path(input int pid);
    logic [8:0] e;
    path.delete();
    case (pid)
      P_CORR:   begin add_line(13, 13, 13, 1); add_line(12, 1, 1, 1); end
      P_DIAGJ:  begin
        add_line(13, 13, 13, 5); add_line(12, 5, 5, 5); pt(6, 6);
        add_line(6, 5, 6, 0); pt(6, 1); add_line(5, 1, 1, 1);
      end
      P_WALL:   begin pt(13, 13); pt(14, 13); add_line(13, 13, 13, 1); add_line(12, 1, 1, 1); end
      P_BADEND: begin add_line(13, 13, 13, 1); add_line(12, 1, 2, 1); end
      P_BADST:  pt(12, 13);
      default:  begin
        add_line(13, 13, 13, 1); add_line(12, 1, 1, 1);
        e = path[5]; e[8] = 1'b1; path[5] = e;
      end
    endcase
  endtask

  task automatic push_frame(input int mz);
    logic [N-1:0] rv;
    exp_bits.delete();
    for (int k = 0; k < NB; k++) begin
      rv = row_of(mz, k / N);
      exp_bits.push_back(rv[k % N]);
    end
    iv_cnt  = 0;
    bit_idx = 0;
  endtask

  task automatic wait_frame_end(input string nm);
    int cnt = 0;
    while (in_valid && cnt < NB + 20) begin tick(); cnt++; end
    chk({nm, "_frame_len"}, iv_cnt, NB);
    chk({nm, "_bits_left"}, exp_bits.size(), 0);
  endtask

  task automatic wait_done(input string nm, input int limit);
    int   cnt = 0;
    exp_t e;
    while (!done && cnt < limit) begin tick(); cnt++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '{-1, -1};
    if (!done) chk({nm, "_done_seen"}, 0, 1);
    else begin
      chk({nm, "_result"}, int'(result), e.res);
      chk({nm, "_path_len"}, int'(path_len), e.len);
      chk({nm, "_busy_low"}, int'(busy), 0);
      chk({nm, "_in_valid_low"}, int'(in_valid), 0);
    end
  endtask

  task automatic solver_nv(input int cycles);
    tick(); tick();
    sol_valid = 1'b1; sol_not_valid = 1'b1;
    for (int k = 0; k < cycles; k++) tick();
    sol_valid = 1'b0; sol_not_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t  v  = vt[i];
    string nm = $sformatf("vec%0d", i);
    int    cnt;
    for (int r = 0; r < N - 1; r++) begin
      row_we = 1'b1; row_addr = 4'(r); row_data = row_of(v.mz, r); tick();
    end
    row_addr = 4'd15; row_data = '1; tick();
    row_addr = 4'(N - 1); row_data = row_of(v.mz, N - 1); start = 1'b1;
    push_frame(v.mz);
    exp_q.push_back('{v.exp_res, v.exp_len});
    tick();
    row_we = 1'b0; start = 1'b0;
    chk({nm, "_busy_at_send"}, int'(busy), 1);
    chk({nm, "_done_cleared"}, int'(done), 0);
    if (v.rsp == R_EARLY) begin
      for (int k = 0; k < 9; k++) tick();
      sol_valid = 1'b1; sol_x = 4'd3; sol_y = 4'd3; tick();
      sol_valid = 1'b0;
      wait_done(nm, 10);
      exp_bits.delete();
      return;
    end
    for (int k = 0; k < 4; k++) tick();
    row_we = 1'b1; row_addr = 4'd13; row_data = '0; start = 1'b1; tick();
    row_we = 1'b0; start = 1'b0;
    wait_frame_end(nm);
    case (v.rsp)
      R_NONE: begin
        cnt = 0;
        while (!done && cnt < TO + 50) begin tick(); cnt++; end
        chk({nm, "_timeout_cycles"}, cnt, TO);
      end
      R_NV1: solver_nv(1);
      R_NV2: solver_nv(2);
      default: begin
        build_path(v.pid);
        tick(); tick(); tick();
        foreach (path[j]) begin
          sol_valid = 1'b1; {sol_not_valid, sol_x, sol_y} = path[j]; tick();
        end
        sol_valid = 1'b0; sol_not_valid = 1'b0;
      end
    endcase
    wait_done(nm, 100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{M_CORR, R_PATH,  P_CORR,   0, 25};
    vt[1] = '{M_DIAG, R_NV1,   P_CORR,   1, 0};
    vt[2] = '{M_ROW0, R_PATH,  P_DIAGJ,  3, 30};
    vt[3] = '{M_ZERO, R_NONE,  P_CORR,   6, 0};
    vt[4] = '{M_CORR, R_PATH,  P_WALL,   4, 27};
    vt[5] = '{M_CORR, R_PATH,  P_BADEND, 5, 24};
    vt[6] = '{M_ZERO, R_PATH,  P_BADST,  2, 1};
    vt[7] = '{M_ZERO, R_NV2,   P_CORR,   7, 0};
    vt[8] = '{M_DIAG, R_EARLY, P_CORR,   7, 0};
    vt[9] = '{M_CORR, R_PATH,  P_CORRNV, 7, 25};

    rst = 1'b1; row_we = 1'b0; row_addr = '0; row_data = '0; start = 1'b0;
    sol_valid = 1'b0; sol_not_valid = 1'b0; sol_x = '0; sol_y = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_in_valid", int'(in_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_path_len", int'(path_len), 0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset in the middle of a frame, then a frame from the cleared store
    for (int r = 0; r < N; r++) begin
      row_we = 1'b1; row_addr = 4'(r); row_data = row_of(M_DIAG, r); tick();
    end
    row_we = 1'b0; start = 1'b1;
    push_frame(M_DIAG);
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("midrst_pre_in_valid", int'(in_valid), 1);
    rst = 1'b1;
    #2;
    chk("midrst_in_valid", int'(in_valid), 0);
    chk("midrst_maze", int'(maze), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_path_len", int'(path_len), 0);
    exp_bits.delete();
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    push_frame(M_ZERO);
    exp_q.push_back('{1, 0});
    tick();
    start = 1'b0;
    wait_frame_end("after_rst");
    solver_nv(1);
    wait_done("after_rst", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
